// File: rtl/udp_meta_pkg.sv
// Shared types for the UDP meta/payload framer.
// Length checking is enabled with `UDP_LEN_CHECK_EN.
package udp_meta_pkg;

  localparam int META_W = 176;
  localparam int HDR_KW = 64;

  localparam logic [HDR_KW-1:0] HDR_KEEP = {HDR_KW{1'b1}};

  typedef struct packed {
    logic [15:0]  len;
    logic [15:0]  my_port;
    logic [15:0]  their_port;
    logic [127:0] their_ip;
  } udp_meta_t;

  typedef enum logic {
    IDLE,
    PAYLOAD
  } fsm_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI4-Stream output register.
// Holds its contents while the consumer stalls.
module axis_out_reg #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_last,
  output logic              load_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [KEEP_W-1:0] m_keep,
  output logic              m_last
);

  assign load_en = !m_valid || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (load_en) begin
      m_valid <= s_valid;
      if (s_valid) begin
        m_data <= s_data;
        m_keep <= s_keep;
        m_last <= s_last;
      end
    end
  end

endmodule

// File: rtl/axis_udp_meta_merge.sv
// Frames one UDP meta word plus its payload into a single AXI4-Stream.
// Optional length check: define `UDP_LEN_CHECK_EN.
module axis_udp_meta_merge
  import udp_meta_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_meta_valid,
  output logic              s_meta_ready,
  input  logic [META_W-1:0] s_meta_data,
  input  logic              s_data_tvalid,
  output logic              s_data_tready,
  input  logic [DATA_W-1:0] s_data_tdata,
  input  logic [KEEP_W-1:0] s_data_tkeep,
  input  logic              s_data_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              err_len
);

  fsm_state_e state;
  fsm_state_e state_nxt;

  udp_meta_t         meta;
  logic              run;
  logic              load_en;
  logic              meta_acc;
  logic              data_acc;
  logic              reg_valid;
  logic [DATA_W-1:0] reg_data;
  logic [KEEP_W-1:0] reg_keep;
  logic              reg_last;
  logic [DATA_W-1:0] hdr_data;

  assign meta     = s_meta_data;
  assign meta_acc = s_meta_valid && s_meta_ready;
  assign data_acc = s_data_tvalid && s_data_tready;

  // Readies stay low until the first clock after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) run <= 1'b0;
    else          run <= 1'b1;
  end

  always_comb begin
    hdr_data = '0;
    hdr_data[META_W-1:0] = s_meta_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (meta_acc && meta.len != 16'd0)
          state_nxt = PAYLOAD;
      PAYLOAD:
        if (data_acc && s_data_tlast)
          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_meta_ready  = 1'b0;
    s_data_tready = 1'b0;
    reg_valid     = 1'b0;
    reg_data      = s_data_tdata;
    reg_keep      = s_data_tkeep;
    reg_last      = s_data_tlast;
    unique case (1'b1)
      (state == IDLE): begin
        s_meta_ready = run && load_en;
        reg_valid    = s_meta_valid && run && load_en;
        reg_data     = hdr_data;
        reg_keep     = KEEP_W'(HDR_KEEP);
        reg_last     = (meta.len == 16'd0);
      end
      (state == PAYLOAD): begin
        s_data_tready = run && load_en;
        reg_valid     = s_data_tvalid && run && load_en;
      end
    endcase
  end

  axis_out_reg #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_out (
    .clk     (aclk),
    .rst_n   (aresetn),
    .s_valid (reg_valid),
    .s_data  (reg_data),
    .s_keep  (reg_keep),
    .s_last  (reg_last),
    .load_en (load_en),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (m_axis_tdata),
    .m_keep  (m_axis_tkeep),
    .m_last  (m_axis_tlast)
  );

`ifdef UDP_LEN_CHECK_EN
  logic [15:0] byte_cnt;
  logic [15:0] byte_sum;
  logic [15:0] len_q;
  logic        err_q;

  function automatic logic [15:0] keep_bytes(
    input logic [KEEP_W-1:0] k
  );
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++)
      n = n + 16'(k[i]);
    return n;
  endfunction

  // Sum wraps modulo 2^16 by width.
  assign byte_sum = byte_cnt + keep_bytes(s_data_tkeep);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      byte_cnt <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (meta_acc) begin
        len_q    <= meta.len;
        byte_cnt <= '0;
      end
      if (data_acc) begin
        if (s_data_tlast) begin
          byte_cnt <= '0;
          err_q    <= (byte_sum != len_q);
        end else begin
          byte_cnt <= byte_sum;
        end
      end
    end
  end

  assign err_len = err_q;
`else
  assign err_len = 1'b0;
`endif

endmodule
